// File: rtl/pc_stack.sv
// pc_stack: program counter with a LIFO return-address stack and sticky overflow/underflow flags
module pc_stack #(
  parameter int ADDR_W = 13,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         incr_pc,
  input  logic                         load_pc,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         clr_err,
  input  logic [ADDR_W-1:0]            ir_addr,
  output logic [ADDR_W-1:0]            pc_addr,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         stack_empty,
  output logic                         stack_full,
  output logic                         ovf_err,
  output logic                         unf_err
);
  localparam int SP_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);
  logic [ADDR_W-1:0] stack [DEPTH];
  logic [ADDR_W-1:0] pc_inc, pc_nxt;
  logic [SP_W-1:0] sp_nxt;
  logic [IDX_W-1:0] push_idx, pop_idx;
  logic do_push, do_pop, ovf_set, unf_set;
  assign stack_empty = sp == '0;
  assign stack_full = sp == SP_W'(DEPTH);
  assign pc_inc = pc_addr + ADDR_W'(1);
  assign push_idx = sp[IDX_W-1:0];
  // sp-1 always fits the index width when popping, so low bits are enough
  assign pop_idx = sp[IDX_W-1:0] - IDX_W'(1);
  assign do_pop = ret && !stack_empty;
  assign unf_set = ret && stack_empty;
  assign do_push = !ret && call && !stack_full;
  assign ovf_set = !ret && call && stack_full;
  always_comb begin
    pc_nxt = ret ? (do_pop ? stack[pop_idx] : pc_addr)
           : call ? (do_push ? ir_addr : pc_addr)
           : load_pc ? ir_addr
           : incr_pc ? pc_inc : pc_addr;
    sp_nxt = do_pop ? sp - SP_W'(1) : do_push ? sp + SP_W'(1) : sp;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_addr <= RESET_ADDR;
      sp <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      pc_addr <= pc_nxt;
      sp <= sp_nxt;
      ovf_err <= ovf_set || (ovf_err && !clr_err);
      unf_err <= unf_set || (unf_err && !clr_err);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && rst_n) stack[push_idx] <= pc_inc;
  end
endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter ADDR_W, default 13, SHALL set the program-address width (8K-byte space at default).
REQ-002 Parameter DEPTH, default 4, SHALL set the return-stack entry count; the legal range SHALL be 2..16.
REQ-003 Parameter RESET_ADDR, default 0, SHALL set the value loaded into pc_addr on reset.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 incr_pc  input  1  SHALL request a sequential advance: pc + 1.
REQ-007 load_pc  input  1  SHALL request an absolute jump to ir_addr.
REQ-008 call  input  1  SHALL request a subroutine call: push pc + 1, then jump to ir_addr.
REQ-009 ret  input  1  SHALL request a return: pop the top of stack into the PC.
REQ-010 clr_err  input  1  SHALL clear the sticky error flags.
REQ-011 ir_addr  input  ADDR_W  SHALL carry the jump/call target.
REQ-012 pc_addr  output  ADDR_W  SHALL carry the current program address, driven directly from a register.
REQ-013 sp  output  clog2(DEPTH+1)  SHALL carry the current stack occupancy, 0..DEPTH.
REQ-014 stack_empty, stack_full  output  1 each  SHALL indicate sp==0 and sp==DEPTH respectively, decoded combinationally from sp.
REQ-015 ovf_err, unf_err  output  1 each  SHALL be sticky overflow and underflow flags.

Function
REQ-016 Per cycle, the block SHALL act on exactly one request, with priority ret > call > load_pc > incr_pc; lower-priority requests asserted in the same cycle SHALL be ignored.
REQ-017 With no request asserted, pc_addr, sp, stack contents and the error flags SHALL hold.
REQ-018 incr_pc SHALL set pc_addr <= pc_addr + 1, modulo 2^ADDR_W; from all-ones it SHALL wrap to 0 with no flag.
REQ-019 load_pc SHALL set pc_addr <= ir_addr; the stack SHALL be untouched.
REQ-020 call with sp<DEPTH SHALL, in one cycle, write (pc_addr+1) mod 2^ADDR_W to entry[sp], increment sp, and set pc_addr <= ir_addr.
REQ-021 call with sp==DEPTH SHALL leave the stack, sp and pc_addr unchanged and set ovf_err.
REQ-022 ret with sp>0 SHALL, in one cycle, set pc_addr <= entry[sp-1] and decrement sp; the popped entry SHALL not be cleared.
REQ-023 ret with sp==0 SHALL leave pc_addr and sp unchanged and set unf_err.
REQ-024 All effects SHALL appear at the output after the edge on which the request is sampled (latency 1 clock); there SHALL be no combinational path from any input to pc_addr.
REQ-025 clr_err SHALL clear ovf_err and unf_err at the next edge; when clr_err coincides with a new error event, the error set SHALL win.
REQ-026 The stack SHALL be LIFO with no wrap-around; entries at index >= sp SHALL not influence outputs.

Reset
REQ-027 While rst_n==0, asynchronously and independently of clk, the block SHALL force pc_addr=RESET_ADDR, sp=0, ovf_err=0 and unf_err=0.
REQ-028 Stack entry contents SHALL not require reset.
REQ-029 Reset asserted mid-call or mid-return SHALL abort that operation with no partial update visible after release.
REQ-030 The first rising edge with rst_n==1 SHALL be processed normally.

Verification
REQ-031 Reset then 3x incr_pc -> pc_addr 0,1,2,3; sp=0; stack_empty=1.
REQ-032 pc_addr=0x0010, call with ir_addr=0x0100 -> pc_addr=0x0100, sp=1, entry0=0x0011; then ret -> pc_addr=0x0011, sp=0.
REQ-033 DEPTH=4: issue 5 nested calls -> after the 4th, stack_full=1; the 5th sets ovf_err=1 with pc_addr and sp unchanged; 4 rets unwind in exact reverse order.
REQ-034 ret with sp=0 -> unf_err=1, pc_addr held; clr_err together with a second empty ret -> unf_err stays 1; clr_err alone -> both flags 0.
REQ-035 pc_addr=0x1FFF with incr_pc -> 0x0000; call at pc_addr=0x1FFF -> pushed value 0x0000; ret+call+load_pc+incr_pc in one cycle -> only ret executes.
REQ-036 Assert rst_n low asynchronously between edges during a call burst -> outputs immediately RESET_ADDR/sp=0/flags 0; normal operation resumes on the first edge after release.
